// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding unit for the 5-stage RV32 pipeline: EX operand bypass selects,
// load-use / RAW stall detection, redirect flush, multicycle-EX hold FSM and a stall counter.
module hazard_fwd_unit #(
    parameter int REG_ADDR_W = 5,
    parameter bit FORWARDING = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    input  logic                  ex_redirect,
    input  logic                  mc_start,
    input  logic                  mc_done,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  id_ex_hold,
    output logic                  mem_bubble,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [CNT_W-1:0]      stall_count
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] stall_count_r;

    logic       ex_match_s;
    logic       mem_match_s;
    logic       hazard_s;
    logic [1:0] fwd_a_raw_s;
    logic [1:0] fwd_b_raw_s;
    logic       pc_en_s;
    logic       if_id_en_s;
    logic       if_id_flush_s;
    logic       id_ex_bubble_s;
    logic       id_ex_hold_s;
    logic       mem_bubble_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;

    // x0 can never be a producer, so a zero source index never matches.
    function automatic logic src_match(input logic                  used,
                                       input logic [REG_ADDR_W-1:0] src,
                                       input logic [REG_ADDR_W-1:0] rd,
                                       input logic                  wr);
        return used && wr && (src != REG_ZERO) && (src == rd);
    endfunction

    // EX/MEM takes priority over MEM/WB because it holds the younger value.
    function automatic logic [1:0] fwd_pick(input logic [REG_ADDR_W-1:0] src);
        logic [1:0] sel;
        if (mem_reg_write && (mem_rd != REG_ZERO) && (mem_rd == src)) begin
            sel = 2'b01;
        end else if (wb_reg_write && (wb_rd != REG_ZERO) && (wb_rd == src)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign ex_match_s  = src_match(id_rs1_used, id_rs1, ex_rd, ex_reg_write)
                       || src_match(id_rs2_used, id_rs2, ex_rd, ex_reg_write);
    assign mem_match_s = src_match(id_rs1_used, id_rs1, mem_rd, mem_reg_write)
                       || src_match(id_rs2_used, id_rs2, mem_rd, mem_reg_write);

    // With bypass only a load in EX must stall; without it any EX or MEM producer must.
    assign hazard_s    = FORWARDING ? (ex_mem_read && ex_match_s) : (ex_match_s || mem_match_s);
    assign fwd_a_raw_s = FORWARDING ? fwd_pick(ex_rs1) : 2'b00;
    assign fwd_b_raw_s = FORWARDING ? fwd_pick(ex_rs2) : 2'b00;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and pipeline control with priority reset > MC hold > redirect > stall > run.
    always_comb begin
        state_nxt_s    = state_r;
        pc_en_s        = 1'b1;
        if_id_en_s     = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_bubble_s = 1'b0;
        id_ex_hold_s   = 1'b0;
        mem_bubble_s   = 1'b0;
        fwd_a_s        = fwd_a_raw_s;
        fwd_b_s        = fwd_b_raw_s;

        case (state_r)
            RUN:     state_nxt_s = (mc_start && !mc_done) ? MC_WAIT : RUN;
            MC_WAIT: state_nxt_s = mc_done ? RUN : MC_WAIT;
            default: state_nxt_s = RUN;
        endcase

        if (!rst_n) begin
            state_nxt_s    = RUN;
            pc_en_s        = 1'b0;
            if_id_en_s     = 1'b0;
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
            fwd_a_s        = 2'b00;
            fwd_b_s        = 2'b00;
        end else if ((state_r == MC_WAIT) && !mc_done) begin
            pc_en_s      = 1'b0;
            if_id_en_s   = 1'b0;
            id_ex_hold_s = 1'b1;
            mem_bubble_s = 1'b1;
        end else if (ex_redirect) begin
            // The stalled instruction, if any, is wrong-path, so squash instead of stalling.
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
        end else if (hazard_s) begin
            pc_en_s        = 1'b0;
            if_id_en_s     = 1'b0;
            id_ex_bubble_s = 1'b1;
        end else begin
            pc_en_s = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (!pc_en_s && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + CNT_ONE;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign pc_en        = pc_en_s;
    assign if_id_en     = if_id_en_s;
    assign if_id_flush  = if_id_flush_s;
    assign id_ex_bubble = id_ex_bubble_s;
    assign id_ex_hold   = id_ex_hold_s;
    assign mem_bubble   = mem_bubble_s;
    assign fwd_a_sel    = fwd_a_s;
    assign fwd_b_sel    = fwd_b_s;
    assign stall_count  = stall_count_r;

endmodule
